sprite_compositor: RTL and testbench
====================================

# sprite_compositor

- Parametrised pixel compositor that merges N sprite/tile layers into the final VGA colour.
- Sits between the per-object renderers (bomberman, bomb, explosion, box, enemies, walls) and the `vgaR/vgaG/vgaB` pins. It replaces the fixed one-hot case mux with a proper priority encoder, so any overlap resolves deterministically.
- Adds a registered two-stage pipeline, a frame-counted death-flash effect and a latched game-over screen.

## Interface

Parameters:
- `N_LAYERS`, 12: number of input layers. Index 0 has the highest priority. Legal range 1..32.
- `RGB_W`, 12: colour width, 4:4:4.
- `BG_COLOR`, 12'h69C: colour used when no layer wins.
- `DEATH_COLOR`, 12'h0F0: colour for the flash phase and the game-over screen.
- `FLASH_FRAMES`, 32: length of the death flash, in frames. Must be ≥1.
- `FLASH_PERIOD`, 4: frames per flash half-cycle. Must be a power of two, ≥1.
- `TRANSPARENT_KEY`, 12'hF0F: colour key. Used only when `SPRITE_COMPOSITOR_TRANSPARENCY_EN` is defined.

Ports:
- `clk` in 1: system clock, 100 MHz. This is the only clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `bright` in 1: high when the pixel is in the visible area, aligned with `layer_*`.
- `frame_start` in 1: one-cycle pulse, once per frame.
- `layer_en` in N_LAYERS: per-layer "pixel on" flags.
- `layer_rgb` in N_LAYERS*RGB_W: flattened colours. Layer i occupies bits [i*RGB_W +: RGB_W].
- `death_pulse` in 1: one-cycle pulse when a life is lost.
- `game_over` in 1: level signal.
- `vga_rgb` out RGB_W: registered colour, {R,G,B}.
- `rgb_valid` out 1: `bright` delayed by 2 cycles.
- `overlay_state` out 2: current FSM state. 0 = NORMAL, 1 = FLASH, 2 = OVER.

## Operation

Stage 1 (registered):
- Winner = lowest index i with `layer_en[i]` set.
- `sel_rgb` = the winner's colour, or `BG_COLOR` if no layer is enabled.
- `bright` is registered alongside as `bright_d1`.

Stage 2 (registered):
- `bright_d1`=0 → `vga_rgb`=0.
- State OVER → `DEATH_COLOR`.
- State FLASH with `phase`=1 → `DEATH_COLOR`.
- Otherwise → `sel_rgb`.
- `rgb_valid` <= `bright_d1`.

Overlay FSM, updated every clock:
- NORMAL:
  - `game_over` → OVER.
  - Else `death_pulse` → FLASH, with `frame_cnt`=0.
- FLASH:
  - `game_over` → OVER. `game_over` takes priority over `death_pulse`.
  - Each `frame_start` increments `frame_cnt`.
  - `frame_start` with `frame_cnt`==FLASH_FRAMES-1 → NORMAL.
  - `death_pulse` restarts the flash: `frame_cnt`=0. This wins over a simultaneous `frame_start`.
- OVER: absorbing; left only via reset.
- `phase` = `frame_cnt[log2(FLASH_PERIOD)]`, so the flash starts with a non-flash phase. With FLASH_PERIOD=1, phase = `frame_cnt[0]`.
- `frame_cnt` is $clog2(FLASH_FRAMES+1) bits wide. It never wraps, because the exit condition fires first.

Reset (`reset_n`=0 at a clock edge):
- State NORMAL, `frame_cnt`=0.
- Both pipeline stages cleared: `vga_rgb`=0, `rgb_valid`=0, `overlay_state`=0.
- Mid-frame reset produces black output until the first valid pixel passes through the pipeline.

## Timing

- Pixel latency: exactly 2 clocks from `layer_*`/`bright` to `vga_rgb`/`rgb_valid`. The top level must delay `hSync`/`vSync` by 2 clocks.
- Throughput: one pixel per clock, no stalls.
- FSM transition: the state register changes on the edge after the event. Stage 2 uses the state register value in the cycle it captures the pixel.
- Stage-1 critical path: an N_LAYERS-way priority encoder plus a mux. It must close timing at 100 MHz for N_LAYERS ≤ 32.

## Configuration

`SPRITE_COMPOSITOR_TRANSPARENCY_EN`:
- Defined: a layer whose colour equals `TRANSPARENT_KEY` is treated as not enabled. Priority falls through to the next enabled layer, then to `BG_COLOR`.
- Undefined: the key is ignored and `layer_en` alone decides the winner. The comparators are not synthesised.

## Structure

- Package `pixel_pkg`: `RGB_W`, `BG_COLOR`, `DEATH_COLOR`, `TRANSPARENT_KEY` constants, and the `overlay_state_t` enum (NORMAL=0, FLASH=1, OVER=2).
- One sub-module, `layer_priority_sel`: combinational N-way priority mux. It includes the transparency qualification and outputs `sel_rgb` and `any_hit`.
- The FSM and both pipeline registers live in `sprite_compositor`.

## Test plan

- **Priority.** N_LAYERS=12, `bright`=1, `layer_en`=12'b0000_0010_0100 (layers 2 and 5 enabled), layer2=12'h123, layer5=12'h456 → `vga_rgb`=12'h123 two clocks later. With `layer_en`=0 → 12'h69C.
- **Blanking and latency.** `bright` pulses high for 1 cycle with layer0=12'hABC → `vga_rgb`=12'hABC and `rgb_valid`=1 for exactly one cycle, at t+2. Otherwise `vga_rgb`=0.
- **Flash.** FLASH_FRAMES=8, FLASH_PERIOD=2, pulse `death_pulse`, then 8 `frame_start` pulses → `overlay_state`=1.
  - Frames 0–1 show normal colour, 2–3 show 12'h0F0, 4–5 normal, 6–7 12'h0F0.
  - `overlay_state` returns to 0 after the 8th `frame_start`.
  - A second `death_pulse` at frame 5 restarts the count at 0.
- **Game over.** Assert `game_over` during FLASH, together with `death_pulse` → `overlay_state`=2. Every bright pixel is 12'h0F0. The state holds after `game_over` deasserts.
- **Reset.** `reset_n`=0 for one cycle while in OVER mid-line → next cycle `vga_rgb`=0, `rgb_valid`=0, `overlay_state`=0. Normal compositing resumes with 2-cycle latency.
- **Transparency** (macro defined). Layer0=12'hF0F enabled, layer1=12'h321 enabled → 12'h321. With the macro undefined → 12'hF0F.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared pixel constants and overlay FSM state encoding for sprite_compositor.
package pixel_pkg;

   localparam int unsigned      RGB_W           = 12;
   localparam logic [RGB_W-1:0] BG_COLOR        = 12'h69C;
   localparam logic [RGB_W-1:0] DEATH_COLOR     = 12'h0F0;
   localparam logic [RGB_W-1:0] TRANSPARENT_KEY = 12'hF0F;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      FLASH  = 2'd1,
      OVER   = 2'd2
   } overlay_state_t;

endpackage

// File: rtl/layer_priority_sel.sv
// Combinational N-way priority mux: the lowest-index qualified layer wins.
// With SPRITE_COMPOSITOR_TRANSPARENCY_EN defined, a layer showing the colour
// key is dropped from the race; otherwise no key comparators exist.
module layer_priority_sel #(
   parameter int unsigned N_LAYERS = 12,
   parameter int unsigned RGB_W    = pixel_pkg::RGB_W
`ifdef SPRITE_COMPOSITOR_TRANSPARENCY_EN
   ,
   parameter logic [RGB_W-1:0] TRANSPARENT_KEY = pixel_pkg::TRANSPARENT_KEY
`endif
) (
   input  logic [N_LAYERS-1:0]       layer_en,
   input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
   output logic [RGB_W-1:0]          sel_rgb,
   output logic                      any_hit
);

   logic [N_LAYERS-1:0] qual_en;

`ifdef SPRITE_COMPOSITOR_TRANSPARENCY_EN
   // Mask out layers whose pixel matches the colour key.
   always_comb begin
      qual_en = layer_en;
      for (int unsigned i = 0; i < N_LAYERS; i++) begin
         if (layer_rgb[i*RGB_W +: RGB_W] == TRANSPARENT_KEY) begin
            qual_en[i] = 1'b0;
         end
      end
   end
`else
   assign qual_en = layer_en;
`endif

   // Priority encode: first qualified layer from index 0 upward supplies the colour.
   always_comb begin
      sel_rgb = '0;
      any_hit = 1'b0;
      for (int unsigned i = 0; i < N_LAYERS; i++) begin
         if (!any_hit && qual_en[i]) begin
            sel_rgb = layer_rgb[i*RGB_W +: RGB_W];
            any_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_compositor.sv
// Sprite/tile layer compositor: priority select -> stage-1 register ->
// overlay (death flash / game over) + blanking -> stage-2 register.
// Optional colour-key transparency via SPRITE_COMPOSITOR_TRANSPARENCY_EN.
module sprite_compositor
   import pixel_pkg::overlay_state_t, pixel_pkg::NORMAL, pixel_pkg::FLASH, pixel_pkg::OVER;
#(
   parameter int unsigned      N_LAYERS     = 12,
   parameter int unsigned      RGB_W        = pixel_pkg::RGB_W,
   parameter logic [RGB_W-1:0] BG_COLOR     = pixel_pkg::BG_COLOR,
   parameter logic [RGB_W-1:0] DEATH_COLOR  = pixel_pkg::DEATH_COLOR,
   parameter int unsigned      FLASH_FRAMES = 32,
   parameter int unsigned      FLASH_PERIOD = 4
`ifdef SPRITE_COMPOSITOR_TRANSPARENCY_EN
   ,
   parameter logic [RGB_W-1:0] TRANSPARENT_KEY = pixel_pkg::TRANSPARENT_KEY
`endif
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      bright,
   input  logic                      frame_start,
   input  logic [N_LAYERS-1:0]       layer_en,
   input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
   input  logic                      death_pulse,
   input  logic                      game_over,
   output logic [RGB_W-1:0]          vga_rgb,
   output logic                      rgb_valid,
   output logic [1:0]                overlay_state
);

   localparam int unsigned CNT_W  = $clog2(FLASH_FRAMES + 1);
   localparam int unsigned PH_IDX = $clog2(FLASH_PERIOD);

   overlay_state_t   state_q, state_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             phase;

   logic [RGB_W-1:0] hit_rgb;
   logic             any_hit;
   logic [RGB_W-1:0] sel_rgb_q, sel_rgb_d;
   logic             bright_d1_q;
   logic [RGB_W-1:0] vga_rgb_q, vga_rgb_d;
   logic             rgb_valid_q;

   layer_priority_sel #(
      .N_LAYERS(N_LAYERS),
      .RGB_W   (RGB_W)
`ifdef SPRITE_COMPOSITOR_TRANSPARENCY_EN
      ,
      .TRANSPARENT_KEY(TRANSPARENT_KEY)
`endif
   ) u_sel (
      .layer_en (layer_en),
      .layer_rgb(layer_rgb),
      .sel_rgb  (hit_rgb),
      .any_hit  (any_hit)
   );

   // Bit PH_IDX of the frame counter; a mask keeps it 0 if that bit is beyond the counter.
   assign phase = |(frame_cnt_q & (CNT_W'(1) << PH_IDX));

   // Overlay FSM next state; game_over beats death_pulse, death_pulse beats frame_start.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         NORMAL: begin
            if (game_over) begin
               state_d = OVER;
            end else if (death_pulse) begin
               state_d     = FLASH;
               frame_cnt_d = '0;
            end
         end
         FLASH: begin
            if (game_over) begin
               state_d = OVER;
            end else if (death_pulse) begin
               frame_cnt_d = '0;
            end else if (frame_start) begin
               if (frame_cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
                  state_d     = NORMAL;
                  frame_cnt_d = '0;
               end else begin
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
               end
            end
         end
         OVER: begin
            state_d = OVER;
         end
         default: begin
            state_d     = NORMAL;
            frame_cnt_d = '0;
         end
      endcase
   end

   // Overlay FSM state and frame counter registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= NORMAL;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Pipeline next values: background fallback for stage 1, overlay and blanking for stage 2.
   always_comb begin
      sel_rgb_d = any_hit ? hit_rgb : BG_COLOR;
      vga_rgb_d = sel_rgb_q;
      if (!bright_d1_q) begin
         vga_rgb_d = '0;
      end else if (state_q == OVER || (state_q == FLASH && phase)) begin
         vga_rgb_d = DEATH_COLOR;
      end
   end

   // Two-stage pixel pipeline registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sel_rgb_q   <= '0;
         bright_d1_q <= 1'b0;
         vga_rgb_q   <= '0;
         rgb_valid_q <= 1'b0;
      end else begin
         sel_rgb_q   <= sel_rgb_d;
         bright_d1_q <= bright;
         vga_rgb_q   <= vga_rgb_d;
         rgb_valid_q <= bright_d1_q;
      end
   end

   assign vga_rgb       = vga_rgb_q;
   assign rgb_valid     = rgb_valid_q;
   assign overlay_state = state_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor (N_LAYERS=12, FLASH_FRAMES=8, FLASH_PERIOD=2).
// Each stimulus cycle queues a state expectation (due next cycle) and a pixel
// expectation (due two cycles later); a negedge monitor pops and compares.
module tb_sprite_compositor;

   logic         clk;
   logic         reset_n;
   logic         bright;
   logic         frame_start;
   logic [11:0]  layer_en;
   logic [143:0] layer_rgb;
   logic         death_pulse;
   logic         game_over;
   logic [11:0]  vga_rgb;
   logic         rgb_valid;
   logic [1:0]   overlay_state;

   typedef struct {
      int          due;
      bit          is_st;
      logic        v;
      logic [11:0] rgb;
      logic [1:0]  st;
      string       nm;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   logic [11:0] fl_rgb [8];

   sprite_compositor #(
      .N_LAYERS    (12),
      .RGB_W       (12),
      .FLASH_FRAMES(8),
      .FLASH_PERIOD(2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bright       (bright),
      .frame_start  (frame_start),
      .layer_en     (layer_en),
      .layer_rgb    (layer_rgb),
      .death_pulse  (death_pulse),
      .game_over    (game_over),
      .vga_rgb      (vga_rgb),
      .rgb_valid    (rgb_valid),
      .overlay_state(overlay_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation that falls due on this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         mon_e  = sb.pop_front();
         checks = checks + 1;
         if (mon_e.due != cyc) begin
            errors = errors + 1;
            $display("FAIL %s: slot missed, due %0d seen %0d", mon_e.nm, mon_e.due, cyc);
         end else if (mon_e.is_st) begin
            if (overlay_state !== mon_e.st) begin
               errors = errors + 1;
               $display("FAIL %s: overlay_state=%0d expected %0d", mon_e.nm, overlay_state, mon_e.st);
            end
         end else if (rgb_valid !== mon_e.v || vga_rgb !== mon_e.rgb) begin
            errors = errors + 1;
            $display("FAIL %s: valid=%b rgb=%h expected valid=%b rgb=%h",
                     mon_e.nm, rgb_valid, vga_rgb, mon_e.v, mon_e.rgb);
         end
      end
   end

   task automatic set_layer(input int i, input logic [11:0] c);
      layer_rgb[i*12 +: 12] = c;
   endtask

   // One stimulus cycle: queue expectations, advance, drop one-cycle pulses.
   task automatic px(input string nm, input logic b, input logic ev,
                     input logic [11:0] erg, input logic [1:0] est);
      exp_t e;
      bright  = b;
      e.due   = cyc + 1;
      e.is_st = 1'b1;
      e.v     = 1'b0;
      e.rgb   = '0;
      e.st    = est;
      e.nm    = {nm, "/state"};
      sb.push_back(e);
      e.due   = cyc + 2;
      e.is_st = 1'b0;
      e.v     = ev;
      e.rgb   = erg;
      e.nm    = nm;
      sb.push_back(e);
      @(negedge clk);
      frame_start = 1'b0;
      death_pulse = 1'b0;
   endtask

   initial begin
      fl_rgb = '{12'h777, 12'h0F0, 12'h0F0, 12'h777, 12'h777, 12'h0F0, 12'h0F0, 12'h777};
      reset_n     = 1'b0;
      bright      = 1'b0;
      frame_start = 1'b0;
      death_pulse = 1'b0;
      game_over   = 1'b0;
      layer_en    = '0;
      layer_rgb   = '0;
      @(negedge clk);

      // Reset
      px("rst0", 1'b1, 1'b0, 12'h000, 2'd0);
      px("rst1", 1'b0, 1'b0, 12'h000, 2'd0);
      reset_n = 1'b1;

      // Priority
      set_layer(2, 12'h123);
      set_layer(5, 12'h456);
      layer_en = 12'b0000_0010_0100;
      px("prio_2_5", 1'b1, 1'b1, 12'h123, 2'd0);
      layer_en = '0;
      px("prio_none", 1'b1, 1'b1, 12'h69C, 2'd0);
      set_layer(0, 12'hABC);
      set_layer(11, 12'hFED);
      layer_en = '1;
      px("prio_all", 1'b1, 1'b1, 12'hABC, 2'd0);
      layer_en = 12'h800;
      px("prio_l11", 1'b1, 1'b1, 12'hFED, 2'd0);
      layer_en = 12'h820;
      px("prio_5_11", 1'b1, 1'b1, 12'h456, 2'd0);

      // Blanking and latency: one bright cycle only
      layer_en = 12'h001;
      px("lat_pre", 1'b0, 1'b0, 12'h000, 2'd0);
      px("lat_hi", 1'b1, 1'b1, 12'hABC, 2'd0);
      px("lat_post0", 1'b0, 1'b0, 12'h000, 2'd0);
      px("lat_post1", 1'b0, 1'b0, 12'h000, 2'd0);

      // Transparency key
      set_layer(0, 12'hF0F);
      set_layer(1, 12'h321);
      layer_en = 12'h003;
`ifdef SPRITE_COMPOSITOR_TRANSPARENCY_EN
      px("transp_fall", 1'b1, 1'b1, 12'h321, 2'd0);
`else
      px("transp_fall", 1'b1, 1'b1, 12'hF0F, 2'd0);
`endif
      layer_en = 12'h001;
`ifdef SPRITE_COMPOSITOR_TRANSPARENCY_EN
      px("transp_bg", 1'b1, 1'b1, 12'h69C, 2'd0);
`else
      px("transp_bg", 1'b1, 1'b1, 12'hF0F, 2'd0);
`endif

      // Death flash: 8 frames, phase toggles every 2 frames
      set_layer(3, 12'h777);
      layer_en = 12'h008;
      death_pulse = 1'b1;
      px("fl_start", 1'b1, 1'b1, 12'h777, 2'd1);
      for (int k = 1; k <= 8; k++) begin
         frame_start = 1'b1;
         px($sformatf("fl_f%0d", k), 1'b1, 1'b1, fl_rgb[k-1], (k < 8) ? 2'd1 : 2'd0);
         px($sformatf("fl_f%0d_b", k), 1'b1, 1'b1, fl_rgb[k-1], (k < 8) ? 2'd1 : 2'd0);
      end

      // Restart: death_pulse wins over frame_start, and alone resets the count
      death_pulse = 1'b1;
      px("rs_start", 1'b1, 1'b1, 12'h777, 2'd1);
      for (int k = 1; k <= 4; k++) begin
         frame_start = 1'b1;
         px($sformatf("rs_f%0d", k), 1'b1, 1'b1, fl_rgb[k-1], 2'd1);
      end
      frame_start = 1'b1;
      death_pulse = 1'b1;
      px("rs_both", 1'b1, 1'b1, 12'h777, 2'd1);
      frame_start = 1'b1;
      px("rs_c1", 1'b1, 1'b1, 12'h777, 2'd1);
      frame_start = 1'b1;
      px("rs_c2", 1'b1, 1'b1, 12'h0F0, 2'd1);
      death_pulse = 1'b1;
      px("rs_alone", 1'b1, 1'b1, 12'h777, 2'd1);

      // Game over during flash, together with death_pulse
      game_over   = 1'b1;
      death_pulse = 1'b1;
      px("go_enter", 1'b1, 1'b1, 12'h0F0, 2'd2);
      game_over = 1'b0;
      px("go_hold", 1'b1, 1'b1, 12'h0F0, 2'd2);
      px("go_blank", 1'b0, 1'b0, 12'h000, 2'd2);
      frame_start = 1'b1;
      px("go_fs", 1'b1, 1'b1, 12'h0F0, 2'd2);
      px("go_pre_rst", 1'b1, 1'b0, 12'h000, 2'd2);

      // Mid-line reset out of OVER
      reset_n = 1'b0;
      px("rst_mid", 1'b1, 1'b0, 12'h000, 2'd0);
      reset_n = 1'b1;
      px("post_rst0", 1'b1, 1'b1, 12'h777, 2'd0);
      px("post_rst1", 1'b1, 1'b1, 12'h777, 2'd0);
      px("idle0", 1'b0, 1'b0, 12'h000, 2'd0);
      px("idle1", 1'b0, 1'b0, 12'h000, 2'd0);

      for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
      checks = checks + 1;
      if (sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
